// File: rtl/hvsync_generator.sv
// rtl/hvsync_generator.sv - VGA-style raster counters with registered h/v sync outputs.
// Optional macro HVSYNC_POS_POLARITY_EN selects active-high syncs (default active-low).
module hvsync_generator #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_BOTTOM  = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

    localparam logic [9:0] H_MAX        = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_MAX        = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_BOTTOM);
    localparam logic [9:0] V_SYNC_END   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

`ifdef HVSYNC_POS_POLARITY_EN
    localparam logic SYNC_ACTIVE = 1'b1;
`else
    localparam logic SYNC_ACTIVE = 1'b0;
`endif
    localparam logic SYNC_IDLE = ~SYNC_ACTIVE;

    logic       h_wrap;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       hsync_next;
    logic       vsync_next;

    always_comb begin
        h_wrap = (hpos == H_MAX);
        h_next = h_wrap ? 10'd0 : hpos + 10'd1;
        v_next = vpos;
        if (h_wrap) begin
            v_next = (vpos == V_MAX) ? 10'd0 : vpos + 10'd1;
        end
        // Syncs decode the next counter state so the registered outputs line up with hpos/vpos.
        hsync_next = ((h_next >= H_SYNC_START) && (h_next <= H_SYNC_END)) ? SYNC_ACTIVE : SYNC_IDLE;
        vsync_next = ((v_next >= V_SYNC_START) && (v_next <= V_SYNC_END)) ? SYNC_ACTIVE : SYNC_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos  <= 10'd0;
            vpos  <= 10'd0;
            hsync <= SYNC_IDLE;
            vsync <= SYNC_IDLE;
        end else begin
            hpos  <= h_next;
            vpos  <= v_next;
            hsync <= hsync_next;
            vsync <= vsync_next;
        end
    end

    assign display_on = ({1'b0, hpos} < 11'(H_DISPLAY)) && ({1'b0, vpos} < 11'(V_DISPLAY));

endmodule

// File: tb/tb_hvsync_generator.sv
// tb/tb_hvsync_generator.sv - scoreboard bench for hvsync_generator (default H timing, short frame).
module tb_hvsync_generator;

    // Horizontal timing at defaults; vertical shortened to V_TOTAL=15 so two frames fit in 24000 clocks.
    localparam int VD = 8;
    localparam int VB = 2;
    localparam int VS = 2;
    localparam int VT = 3;

`ifdef HVSYNC_POS_POLARITY_EN
    localparam logic ACT = 1'b1;
`else
    localparam logic ACT = 1'b0;
`endif
    localparam logic IDL = ~ACT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hsync, vsync, display_on;
    logic [9:0] hpos, vpos;

    hvsync_generator #(
        .H_DISPLAY(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
        .display_on(display_on), .hpos(hpos), .vpos(vpos)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    at;
        int    h;
        int    v;
        logic  hs;
        logic  vs;
        logic  de;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc;
    bit   phase_a = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic push(input string name, input int at, input int h, input int v,
                        input bit hs_on, input bit vs_on, input logic de);
        exp_t e;
        e.name = name; e.at = at; e.h = h; e.v = v;
        e.hs = hs_on ? ACT : IDL;
        e.vs = vs_on ? ACT : IDL;
        e.de = de;
        exp_q.push_back(e);
    endtask

    task automatic check_int(input string name, input int act_v, input int exp_v);
        n_cmp++;
        if (act_v != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
        end
    endtask

    // Monitor: pops the head entry when the current cycle matches it; also samples right after a reset edge.
    always @(negedge clk or negedge rst_n) begin
        #1;
        if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (hpos !== 10'(e.h) || vpos !== 10'(e.v) || hsync !== e.hs ||
                vsync !== e.vs || display_on !== e.de) begin
                n_bad++;
                $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b de=%b expected h=%0d v=%0d hs=%b vs=%b de=%b",
                         e.name, hpos, vpos, hsync, vsync, display_on,
                         e.h, e.v, e.hs, e.vs, e.de);
            end
        end
    end

    // Measurements over the first run: sync widths, vsync edge spacing, vpos stability within a line.
    int   hs_cnt_line0 = 0;
    int   vs_cnt_frame0 = 0;
    int   vs_edge[$];
    int   vpos_glitch = 0;
    logic prev_vs = IDL;
    logic [9:0] prev_vpos = 10'd0;

    always @(negedge clk) begin
        #1;
        if (rst_n && phase_a && cyc > 0) begin
            if (cyc < 800 && hsync === ACT) hs_cnt_line0++;
            if (cyc <= 12000 && vsync === ACT) vs_cnt_frame0++;
            if (prev_vs !== ACT && vsync === ACT) vs_edge.push_back(cyc);
            if (hpos != 10'd0 && vpos != prev_vpos) vpos_glitch++;
            prev_vs   = vsync;
            prev_vpos = vpos;
        end
    end

    initial begin
        // name, cycle, hpos, vpos, hsync asserted, vsync asserted, display_on
        push("reset_state",     0,   0,  0, 0, 0, 1);
        push("first_edge",      1,   1,  0, 0, 0, 1);
        push("last_visible",  639, 639,  0, 0, 0, 1);
        push("first_blank",   640, 640,  0, 0, 0, 0);
        push("hs_before",     655, 655,  0, 0, 0, 0);
        push("hs_start",      656, 656,  0, 1, 0, 0);
        push("hs_end",        751, 751,  0, 1, 0, 0);
        push("hs_after",      752, 752,  0, 0, 0, 0);
        push("line0_last",    799, 799,  0, 0, 0, 0);
        push("line1_start",   800,   0,  1, 0, 0, 1);
        push("line5_last",   4799, 799,  5, 0, 0, 0);
        push("line6_start",  4800,   0,  6, 0, 0, 1);
        push("vs_before",    7999, 799,  9, 0, 0, 0);
        push("vs_start",     8000,   0, 10, 0, 1, 0);
        push("vs_end",       9599, 799, 11, 0, 1, 0);
        push("vs_after",     9600,   0, 12, 0, 0, 0);
        push("frame_last",  11999, 799, 14, 0, 0, 0);
        push("frame_wrap",  12000,   0,  0, 0, 0, 1);
        push("vs2_start",   20000,   0, 10, 0, 1, 0);
        push("pre_reset",   21100, 300, 11, 0, 1, 0);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (21100) @(posedge clk);
        @(negedge clk);
        #2;
        phase_a = 1'b0;
        push("async_reset",     0,   0,  0, 0, 0, 1);
        push("restart_edge",    1,   1,  0, 0, 0, 1);
        push("restart_hs",    656, 656,  0, 1, 0, 0);
        push("restart_line",  800,   0,  1, 0, 0, 1);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        repeat (810) @(posedge clk);
        @(negedge clk);
        #3;

        check_int("hsync_width_line0", hs_cnt_line0, 96);
        check_int("vsync_width_frame0", vs_cnt_frame0, 1600);
        check_int("vsync_edge_count", vs_edge.size(), 2);
        check_int("vsync_edge_spacing", (vs_edge.size() >= 2) ? vs_edge[1] - vs_edge[0] : -1, 12000);
        check_int("vpos_stable_in_line", vpos_glitch, 0);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never sampled, expected at cycle %0d", e.name, e.at);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hvsync_generator.md
HVSYNC_GENERATOR -- requirements
Module: hvsync_generator

Interface
- REQ-001: Parameter H_DISPLAY SHALL default to 640; it is the number of visible pixels per line.
- REQ-002: Parameter H_FRONT SHALL default to 16; it is the horizontal front porch, in clocks.
- REQ-003: Parameter H_SYNC SHALL default to 96; it is the horizontal sync width, in clocks.
- REQ-004: Parameter H_BACK SHALL default to 48; it is the horizontal back porch, in clocks.
- REQ-005: Parameter V_DISPLAY SHALL default to 480; it is the number of visible lines per frame.
- REQ-006: Parameter V_BOTTOM SHALL default to 10; it is the vertical front porch, in lines.
- REQ-007: Parameter V_SYNC SHALL default to 2; it is the vertical sync width, in lines.
- REQ-008: Parameter V_TOP SHALL default to 33; it is the vertical back porch, in lines.
- REQ-009: Port clk SHALL be an input, 1 bit wide; it is the pixel clock, and every output is referenced to its rising edge.
- REQ-010: Port rst_n SHALL be an input, 1 bit wide; it is the reset.
- REQ-011: The block SHALL use one clock; reset is asynchronous and active-low.
- REQ-012: Port hsync SHALL be an output, 1 bit wide; it is the horizontal sync and is registered.
- REQ-013: Port vsync SHALL be an output, 1 bit wide; it is the vertical sync and is registered.
- REQ-014: Port display_on SHALL be an output, 1 bit wide; it is high while the current pixel is inside the visible area.
- REQ-015: Port hpos SHALL be an output, 10 bits wide; it is the current column counter.
- REQ-016: Port vpos SHALL be an output, 10 bits wide; it is the current line counter.

Function
- REQ-017: H_TOTAL SHALL equal H_DISPLAY+H_FRONT+H_SYNC+H_BACK (default 800), and V_TOTAL SHALL equal V_DISPLAY+V_BOTTOM+V_SYNC+V_TOP (default 525).
- REQ-018: Parameter combinations with H_TOTAL or V_TOTAL greater than 1024 SHALL be unsupported.
- REQ-019: hpos SHALL increment by 1 on every clk edge, and SHALL wrap from H_TOTAL-1 (799) to 0.
- REQ-020: vpos SHALL increment by 1 only on the edge where hpos wraps, and SHALL otherwise hold.
- REQ-021: vpos SHALL wrap from V_TOTAL-1 (524) to 0 on the same edge that hpos wraps from 799 to 0.
- REQ-022: Frame length SHALL be exactly H_TOTAL*V_TOTAL clocks (default 420000).
- REQ-023: display_on SHALL be combinational: (hpos < H_DISPLAY) AND (vpos < V_DISPLAY).
- REQ-024: hsync SHALL be asserted exactly while hpos is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. [656, 751] by default, which is 96 clocks per line.
- REQ-025: hsync SHALL be registered from the next-state counter value, so that it has zero-cycle skew relative to hpos.
- REQ-026: vsync SHALL be asserted exactly while vpos is in [V_DISPLAY+V_BOTTOM, V_DISPLAY+V_BOTTOM+V_SYNC-1], i.e. [490, 491] by default, which is 1600 clocks per frame.
- REQ-027: vsync SHALL be registered from the next-state value with the same alignment as hsync, and SHALL be independent of hpos.
- REQ-028: The asserted sync level SHALL be 0 (negative polarity) by default.
- REQ-029: hsync and vsync SHALL be glitch-free because they are register outputs.

Reset
- REQ-030: While rst_n is low, the block SHALL immediately force hpos=0, vpos=0, hsync deasserted and vsync deasserted, independent of clk.
- REQ-031: During reset, display_on SHALL read 1, consistent with hpos=0 and vpos=0.
- REQ-032: Reset asserted mid-line or mid-frame SHALL abort the current frame with no partial-sync residue.
- REQ-033: On the first clk edge after rst_n rises, hpos SHALL become 1.

Configuration
- REQ-034: When macro HVSYNC_POS_POLARITY_EN is defined, the asserted sync level SHALL be 1 (positive polarity) and the reset and idle sync level SHALL be 0.
- REQ-035: When HVSYNC_POS_POLARITY_EN is undefined, syncs SHALL be active-low, and their reset and idle level SHALL be 1.
- REQ-036: HVSYNC_POS_POLARITY_EN SHALL NOT affect counter timing or display_on.

Verification
- REQ-037: Reset and line start: rst_n low -> hpos=0, vpos=0, hsync=1, vsync=1, display_on=1; release and 639 clocks later -> hpos=639, display_on=1; next clock -> hpos=640, display_on=0.
- REQ-038: Horizontal sync: on line 0, hsync=0 exactly for hpos 656..751 (96 clocks) and 1 at hpos 655 and 752.
- REQ-039: Line wrap: hpos=799, vpos=5 -> next clock hpos=0, vpos=6; during a line, vpos SHALL be constant.
- REQ-040: Frame wrap: hpos=799, vpos=524 -> next clock hpos=0, vpos=0.
- REQ-041: Vertical sync: vsync=0 for all of vpos 490..491 (1600 clocks) and 1 elsewhere; across two frames, the vsync falling edges SHALL be 420000 clocks apart.
- REQ-042: Asynchronous reset: rst_n pulsed low between edges at hpos=300, vpos=491 -> outputs return to reset values before the next edge, and the count restarts from 0.
- REQ-043: Polarity option: with HVSYNC_POS_POLARITY_EN defined, repeating REQ-038 and REQ-041 SHALL give inverted sync levels and identical counter timing.
